// File: rtl/paddle_controller.sv
// paddle_controller: per-frame paddle centre from synchronised, debounced buttons; define PADDLE_ACCEL_EN for the IDLE/ACCEL/CRUISE speed ramp
module paddle_controller #(
  parameter int PADDLE_WIDTH    = 99,
  parameter int SCREEN_WIDTH    = 640,
  parameter int X_RESET         = 320,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 8,
  parameter int ACCEL_FRAMES    = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       lock,
  output logic [9:0] x,
  output logic       at_edge,
  output logic       moving
);
  localparam int X_MIN = PADDLE_WIDTH / 2;
  localparam int X_MAX = SCREEN_WIDTH - (PADDLE_WIDTH + 1) / 2;
  localparam int CW = $clog2((DEBOUNCE_FRAMES > ACCEL_FRAMES ? DEBOUNCE_FRAMES : ACCEL_FRAMES) + 1);
  localparam int SW = $clog2((SPEED_MAX > SPEED_MIN ? SPEED_MAX : SPEED_MIN) + 1);
  localparam logic signed [10:0] LO = 11'(X_MIN);
  localparam logic signed [10:0] HI = 11'(X_MAX);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         meta_q, sync_q;
  logic [1:0]         db_q, db_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [9:0]         x_q, x_d;
  logic               dir_q, dir_d;
  logic [SW-1:0]      step;
  logic signed [10:0] sum;
  logic               go, right, mv;
`ifdef PADDLE_ACCEL_EN
  logic [SW-1:0]      speed_q, speed_d;
  logic [CW-1:0]      acc_q, acc_d;
`endif

  // bit 1 is left, bit 0 is right; exactly one debounced button gives a direction
  assign go      = db_q[1] ^ db_q[0];
  assign right   = db_q[0];
  assign x       = x_q;
  assign at_edge = (x_q == LO[9:0]) || (x_q == HI[9:0]);
  assign moving  = state_q != IDLE;

  // debounce: count ticks where the synchronised button disagrees, flip once the run is long enough
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i] ^ (frame_tick && sync_q[i] != db_q[i] && cnt_q[i] == CW'(DEBOUNCE_FRAMES - 1));
      cnt_d[i] = !frame_tick ? cnt_q[i] : (sync_q[i] == db_q[i] || db_d[i] != db_q[i]) ? '0 : cnt_q[i] + 1'b1;
    end
  end

  // speed state machine and clamped move, evaluated once per frame using last frame's debounced buttons
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mv      = 1'b0;
`ifdef PADDLE_ACCEL_EN
    speed_d = speed_q;
    acc_d   = acc_q;
    step    = speed_q;
`else
    step    = SW'(SPEED_MAX);
`endif
    if (frame_tick) begin
      if (lock || !go) begin
        state_d = IDLE;
`ifdef PADDLE_ACCEL_EN
        speed_d = SW'(SPEED_MIN);
        acc_d   = '0;
`endif
      end else begin
        mv    = 1'b1;
        dir_d = right;
`ifdef PADDLE_ACCEL_EN
        if (state_q == IDLE || right != dir_q) begin
          state_d = ACCEL;
          step    = SW'(SPEED_MIN);
          speed_d = SW'(SPEED_MIN);
          acc_d   = CW'(state_q == IDLE);
        end else if (state_q == ACCEL) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == CW'(ACCEL_FRAMES)) begin
            acc_d   = '0;
            speed_d = speed_q + 1'b1;
            state_d = (speed_d == SW'(SPEED_MAX)) ? CRUISE : ACCEL;
          end
        end
`else
        state_d = CRUISE;
`endif
      end
    end
    sum = $signed({1'b0, x_q}) + (dir_d ? $signed({{(11-SW){1'b0}}, step}) : -$signed({{(11-SW){1'b0}}, step}));
    x_d = !mv ? x_q : (sum < LO) ? LO[9:0] : (sum > HI) ? HI[9:0] : sum[9:0];
  end

  // registers: synchroniser shifts every cycle, the rest only changes through the tick-gated *_d terms
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= '0;
      sync_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 10'(X_RESET);
      dir_q   <= 1'b0;
      state_q <= IDLE;
`ifdef PADDLE_ACCEL_EN
      speed_q <= SW'(SPEED_MIN);
      acc_q   <= '0;
`endif
    end else begin
      meta_q  <= {btn_left, btn_right};
      sync_q  <= meta_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      state_q <= state_d;
`ifdef PADDLE_ACCEL_EN
      speed_q <= speed_d;
      acc_q   <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: stimulus queues the expected response of every frame tick, a monitor checks it after the tick edge
`timescale 1ns/1ps
module tb_paddle_controller;
  typedef struct { string nm; int ex; int em; } exp_t;

  logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, lock = 1'b0;
  logic [9:0] x;
  logic       at_edge, moving;
  int         total = 0, bad = 0;
  exp_t       q[$];
  int         xm = 320, km = 0, dm = 0, mm = 0;

`ifdef PADDLE_ACCEL_EN
  localparam int RAMP [8]  = '{320, 320, 320, 322, 324, 326, 328, 331};
  localparam int LTAIL [6] = '{54, 52, 50, 49, 49, 49};
  localparam int REV_X     = 450;
`else
  localparam int RAMP [8]  = '{320, 320, 320, 328, 336, 344, 352, 360};
  localparam int LTAIL [6] = '{49, 49, 49, 49, 49, 49};
  localparam int REV_X     = 528;
`endif

  paddle_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .lock(lock), .x(x), .at_edge(at_edge), .moving(moving)
  );

  always #5 clk = ~clk;

  // pixels moved on the k-th consecutive moving frame
  function automatic int step(input int k);
`ifdef PADDLE_ACCEL_EN
    int s = 2 + (k - 1) / 4;
    return s > 8 ? 8 : s;
`else
    return 8 + 0 * k;
`endif
  endfunction

  task automatic check(input string nm, input string what, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s %s: got %0d expected %0d", nm, what, act, req);
    end
  endtask

  // monitor: after every tick edge, compare against the oldest queued expectation
  always @(posedge clk) if (frame_tick) begin : mon
    exp_t e;
    @(negedge clk);
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL queue: tick seen with no expectation queued");
    end else begin
      e = q.pop_front();
      check(e.nm, "x", int'(x), e.ex);
      check(e.nm, "moving", int'(moving), e.em);
      check(e.nm, "at_edge", int'(at_edge), (e.ex == 49 || e.ex == 590) ? 1 : 0);
    end
  end

  task automatic do_tick(input string nm, input int ex, input int em, input bit hold = 0);
    @(negedge clk);
    frame_tick = 1'b1;
    q.push_back('{nm, ex, em});
    if (!hold) begin
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  // reference: dir is the debounced direction the DUT sees on this tick
  task automatic madv(input int dir);
    if (lock || dir == 0) begin
      km = 0;
      mm = 0;
    end else begin
      if (mm != 0 && dir != dm) km = 0;
      km++;
      dm = dir;
      mm = 1;
      xm += dir * step(km);
      xm = xm < 49 ? 49 : xm > 590 ? 590 : xm;
    end
  endtask

  task automatic mtick(input string nm, input int dir, input bit hold = 0);
    madv(dir);
    do_tick(nm, xm, mm, hold);
  endtask

  task automatic set_btn(input logic l, input logic r);
    @(negedge clk);
    frame_tick = 1'b0;
    btn_left   = l;
    btn_right  = r;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input logic l, input logic r);
    @(negedge clk);
    frame_tick = 1'b0;
    reset      = 1'b1;
    lock       = 1'b0;
    btn_left   = l;
    btn_right  = r;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    xm = 320; km = 0; dm = 0; mm = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    // reset held across a frame tick
    repeat (2) @(negedge clk);
    do_tick("reset_tick", 320, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    mtick("idle", 0);
    // debounce latency and speed ramp, then right clamp with some back-to-back ticks
    do_reset(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      madv(i <= 3 ? 0 : 1);
      do_tick("ramp", RAMP[i-1], i >= 4 ? 1 : 0);
    end
    for (int i = 9; i <= 200; i++) mtick("right_run", 1, (i % 5 == 1) && i < 200);
    // reversal out of full speed
    do_reset(1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) mtick("rev_deb", 0);
    for (int i = 1; i <= 24; i++) mtick("rev_run", 1);
    set_btn(1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) mtick("rev_lag", 1);
    madv(-1);
    do_tick("reversal", REV_X, 1);
    // left clamp, approached in small steps by pulsing lock
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) mtick("left_deb", 0);
    guard = 0;
    while (xm > 60 && guard < 200) begin
      mtick("left_run", -1);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      lock = (i % 2 == 0);
      mtick("left_lock", -1);
    end
    lock = 1'b0;
    for (int i = 0; i < 6; i++) begin
      madv(-1);
      do_tick("left_clamp", LTAIL[i], 1);
    end
    // glitch rejection: two-tick presses never flip, counter clears in between
    do_reset(1'b0, 1'b0);
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) mtick("glitch_a", 0);
    set_btn(1'b0, 1'b0);
    mtick("glitch_gap", 0);
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) mtick("glitch_b", 0);
    set_btn(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) mtick("glitch_end", 0);
    // both buttons debounced: no motion; dropping left then moves right
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) mtick("both", 0);
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) mtick("both_lag", 0);
    for (int i = 0; i < 2; i++) mtick("both_right", 1);
    // lock freezes the paddle and restarts from minimum speed
    do_reset(1'b0, 1'b1);
    lock = 1'b1;
    for (int i = 1; i <= 6; i++) mtick("locked", i > 3 ? 1 : 0);
    lock = 1'b0;
    for (int i = 0; i < 2; i++) mtick("unlocked", 1);
    lock = 1'b1;
    mtick("relock", 1);
    lock = 1'b0;
    mtick("unlock2", 1);
    // reset mid-move wins over the tick
    @(negedge clk);
    reset = 1'b1;
    do_tick("reset_mid", 320, 0);
    reset = 1'b0;
    xm = 320; km = 0; dm = 0; mm = 0;
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) mtick("post_reset", 0);
    mtick("post_move", 1);
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/paddle_controller.md
# paddle_controller

Sequential paddle position generator for the breakout game. It turns the player's left/right buttons into the paddle centre coordinate `x` that the paddle drawing logic consumes, and updates it once per video frame. The block provides input synchronisation, per-frame debouncing, an IDLE/ACCEL/CRUISE speed state machine and clamping to the playfield, so the drawn paddle never leaves the 640-pixel visible area.

## Interface
- `PADDLE_WIDTH`, 99, paddle width in pixels; must be odd and match the drawer.
- `SCREEN_WIDTH`, 640, visible horizontal pixels.
- `X_RESET`, 320, `x` after reset.
- `SPEED_MIN`, 2, pixels/frame when movement starts.
- `SPEED_MAX`, 8, maximum pixels/frame.
- `ACCEL_FRAMES`, 4, moved frames per speed step.
- `DEBOUNCE_FRAMES`, 3, consecutive equal frame samples needed to change a debounced button.

- `clk` in 1: system/pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame from the VGA timing block.
- `btn_left` in 1: raw asynchronous button.
- `btn_right` in 1: raw asynchronous button.
- `lock` in 1: holds the paddle, for example during game over or serve.
- `x` out 10: paddle centre column.
- `at_edge` out 1: `x` equals `X_MIN` or `X_MAX`.
- `moving` out 1: state is ACCEL or CRUISE.

## Operation
- **Clamp limits.** `X_MIN = PADDLE_WIDTH/2` (49). `X_MAX = SCREEN_WIDTH - (PADDLE_WIDTH+1)/2` (590).
- **Synchronisation.** Each button passes through a 2-flop synchroniser. All further logic uses the synchronised value.
- **Debounce.**
  - On every `frame_tick`, each synchronised button is compared with its debounced bit.
  - If they differ, that button's counter increments. If they are equal, the counter clears.
  - When the counter reaches `DEBOUNCE_FRAMES`, the debounced bit flips and the counter clears.
- **Direction.** Derived from the debounced bits as they were before the current tick:
  - left only: −1
  - right only: +1
  - both or neither: none
- **State machine.** Evaluated only on `frame_tick`.
  - IDLE: speed = `SPEED_MIN`, accel count = 0. Direction ≠ none and `lock`=0 → ACCEL, and this same tick moves by `SPEED_MIN`.
  - ACCEL: each tick moves by the current speed and increments the accel count. When the count reaches `ACCEL_FRAMES`, speed += 1 and the count clears. When speed reaches `SPEED_MAX` → CRUISE.
  - CRUISE: moves by `SPEED_MAX`.
  - ACCEL/CRUISE, direction none → IDLE, no move.
  - ACCEL/CRUISE, direction reversed → ACCEL, speed = `SPEED_MIN`, count = 0; this tick moves by `SPEED_MIN` in the new direction.
  - `lock`=1 → IDLE, no move; it still ranks below `reset`.
- **Arithmetic.**
  - Compute `x ± speed` in 11-bit signed, then clamp to [`X_MIN`, `X_MAX`].
  - A clamped move keeps the current state and speed.
- `at_edge` and `moving` are combinational decodes of the registered `x` and state.

## Timing
- **Reset values:** `x`=`X_RESET`, `at_edge`=0, `moving`=0, state IDLE, speed `SPEED_MIN`, all counters, synchronisers and debounced bits 0.
- **Reset priority:** `reset` overrides `frame_tick` and `lock` in the same cycle. Reset mid-move returns to IDLE and centres the paddle on the next edge.
- **Update edge:** `x` updates only on the clock edge where `frame_tick`=1 and is valid from the following cycle. Between ticks it is constant.
- **Press latency:**
  - 2 cycles through the synchroniser.
  - `DEBOUNCE_FRAMES` ticks until the debounced bit flips.
  - The first move occurs on the next tick.
- **Back-to-back ticks:** `frame_tick` high on consecutive cycles counts as separate frames.

## Configuration
- **`PADDLE_ACCEL_EN` defined:** acceleration behaves as described above.
- **`PADDLE_ACCEL_EN` undefined:**
  - No ACCEL state. IDLE goes directly to CRUISE, and every move uses `SPEED_MAX`, including after a reversal.
  - The accel counter is not built.
  - `SPEED_MIN` and `ACCEL_FRAMES` are ignored.

## Test plan
- **Reset:** assert `reset` for 2 cycles, including while `frame_tick`=1 → `x`=320, `moving`=0, `at_edge`=0.
- **Debounce and acceleration** (`PADDLE_ACCEL_EN` defined): hold `btn_right` steadily.
  - Ticks 1–3 → `x`=320; the debounced bit flips at tick 3.
  - Ticks 4–7 → `x`=322, 324, 326, 328.
  - Tick 8 → 331. `moving`=1 from tick 4.
- **Right clamp:** hold right for 200 frames → `x` reaches 590 and never exceeds it, `at_edge`=1, state CRUISE.
- **Left clamp:** from `x`=52, speed 2, holding left → 50, then 49, then stays at 49; `at_edge`=1.
- **Glitch rejection:** `btn_right` high for 2 ticks, then low → `x` remains 320, `moving`=0.
  - Both buttons debounced → no motion.
  - Reversal from CRUISE at `x`=400 → next tick `x`=398 (`SPEED_MIN`).
  - `lock`=1 → `x` frozen.
